lcd_command_responder: RTL

//  Responder end of the LCD update command interface. Accepts clear/line1/line2 write requests and their handshake.

---
 rtl/lcd_command_responder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/lcd_command_responder.sv
// LCD command responder: expands clear/line1/line2 requests into PMOD CLS
// ANSI byte streams and hands them to the SPI transmitter one byte at a time.
module lcd_command_responder #(
    parameter int          parm_fast_simulation = 0,
    parameter logic [23:0] parm_guard_ticks     = 24'd2500
) (
    input  logic         i_clk_20mhz,
    input  logic         i_rstn_20mhz,
    input  logic         i_ce_2_5mhz,
    input  logic         i_lcd_wr_clear_display,
    input  logic         i_lcd_wr_text_line1,
    input  logic         i_lcd_wr_text_line2,
    input  logic [127:0] i_dat_ascii_line1,
    input  logic [127:0] i_dat_ascii_line2,
    output logic         o_lcd_command_ready,
    output logic [7:0]   o_tx_byte,
    output logic         o_tx_valid,
    input  logic         i_tx_ready
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;

    localparam logic [1:0] CMD_CLEAR = 2'd0;
    localparam logic [1:0] CMD_LINE1 = 2'd1;
    localparam logic [1:0] CMD_LINE2 = 2'd2;

    localparam logic [23:0] GUARD =
        (parm_fast_simulation != 0) ? 24'd25 : parm_guard_ticks;

    logic [1:0]   state_q, state_d;
    logic [1:0]   cmd_q, cmd_d;
    logic [4:0]   idx_q, idx_d;
    logic [23:0]  guard_q, guard_d;
    logic [127:0] line1_q, line1_d;
    logic [127:0] line2_q, line2_d;
    logic [7:0]   byte_q, byte_d;
    logic         valid_q, valid_d;
    logic [4:0]   last_idx;

    // Byte at a given sequence position; text chars start at index 6
    function automatic logic [7:0] seq_byte(
        input logic [1:0]   cmd,
        input logic [4:0]   idx,
        input logic [127:0] l1,
        input logic [127:0] l2
    );
        logic [127:0] t;
        t = (cmd == CMD_LINE1) ? l1 : l2;
        t = t << {idx - 5'd6, 3'b000};
        case (idx)
            5'd0:    seq_byte = 8'h1B;
            5'd1:    seq_byte = 8'h5B;
            5'd2:    seq_byte = (cmd == CMD_CLEAR) ? 8'h6A :
                                (cmd == CMD_LINE1) ? 8'h30 : 8'h31;
            5'd3:    seq_byte = 8'h3B;
            5'd4:    seq_byte = 8'h30;
            5'd5:    seq_byte = 8'h48;
            default: seq_byte = t[127:120];
        endcase
    endfunction

    assign last_idx = (cmd_q == CMD_CLEAR) ? 5'd2 : 5'd21;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        guard_d = guard_q;
        line1_d = line1_q;
        line2_d = line2_q;
        byte_d  = byte_q;
        valid_d = valid_q;
        if (i_ce_2_5mhz) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_lcd_wr_clear_display || i_lcd_wr_text_line1 ||
                        i_lcd_wr_text_line2) begin
                        cmd_d   = i_lcd_wr_clear_display ? CMD_CLEAR :
                                  i_lcd_wr_text_line1    ? CMD_LINE1 :
                                                           CMD_LINE2;
                        line1_d = i_dat_ascii_line1;
                        line2_d = i_dat_ascii_line2;
                        idx_d   = 5'd0;
                        byte_d  = 8'h1B;
                        valid_d = 1'b1;
                        state_d = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (i_tx_ready) begin
                        if (idx_q == last_idx) begin
                            idx_d   = 5'd0;
                            byte_d  = 8'h00;
                            valid_d = 1'b0;
                            guard_d = 24'd0;
                            state_d = ST_GUARD;
                        end else begin
                            idx_d  = idx_q + 5'd1;
                            byte_d = seq_byte(cmd_q, idx_q + 5'd1,
                                              line1_q, line2_q);
                        end
                    end
                end
                ST_GUARD: begin
                    if (guard_q == GUARD - 24'd1) begin
                        guard_d = 24'd0;
                        state_d = ST_IDLE;
                    end else begin
                        guard_d = guard_q + 24'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_CLEAR;
            idx_q   <= 5'd0;
            guard_q <= 24'd0;
            line1_q <= 128'd0;
            line2_q <= 128'd0;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            guard_q <= guard_d;
            line1_q <= line1_d;
            line2_q <= line2_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
        end
    end

    assign o_lcd_command_ready = (state_q == ST_IDLE);
    assign o_tx_byte           = byte_q;
    assign o_tx_valid          = valid_q;

endmodule
